// File: rtl/mc_sequencer_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS control sequencer.
//   - opcode constants for the supported instruction subset
//   - FSM state encoding
//   - instruction class produced by mc_opcode_class
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_R,
        ALU_I,
        LOAD,
        STORE,
        BRANCH,
        JUMP,
        ILLEGAL
    } iclass_e;

endpackage

// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if: instruction- and data-memory handshake bundle.
//   master (sequencer): drives imem_req/imem_addr, dmem_req/dmem_we
//   slave  (memory)   : drives imem_ack/imem_rdata, dmem_ack
// Acks are single-cycle completion pulses sampled on the rising clock edge.
interface mc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/mc_sequencer_opcode_class.sv
// mc_opcode_class: purely combinational opcode -> instruction class decode.
//   opcode : instr[31:26]
//   iclass : ALU_R / ALU_I / LOAD / STORE / BRANCH / JUMP / ILLEGAL
module mc_opcode_class
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    output iclass_e    iclass
);

    always_comb begin
        iclass = ILLEGAL;
        case (opcode)
            OP_RTYPE:              iclass = ALU_R;
            OP_ADDI, OP_ORI, OP_LUI: iclass = ALU_I;
            OP_LW:                 iclass = LOAD;
            OP_SW:                 iclass = STORE;
            OP_BEQ:                iclass = BRANCH;
            OP_J:                  iclass = JUMP;
            default:               iclass = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control FSM for the single-issue MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// owns PC and IR, resolves beq/j, halts on illegal opcodes, and counts
// non-idle cycles and retired instructions.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : run enable, only looked at in IDLE
//   mem         : imem/dmem request/ack handshake (master side)
//   instr       : instruction register
//   alu_zero    : ALU zero flag, used in EXECUTE for beq
//   alu_src, reg_write, mem_to_reg : datapath strobes
//   pc, halted, cycle_cnt, instret_cnt : architectural status
// Every output is decoded from flops only; no input reaches an output
// combinationally.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    mc_sequencer_if.master        mem,
    output logic [31:0]           instr,
    input  logic                  alu_zero,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic [31:0]           pc,
    output logic                  halted,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           instret_cnt
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ret_q, ret_d;
    logic        retire;
    iclass_e     iclass;
    logic [31:0] br_off;

    // Classification runs off the IR, so it is stable from DECODE onward.
    mc_opcode_class u_cls (
        .opcode (ir_q[31:26]),
        .iclass (iclass)
    );

    assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem.imem_ack) begin
                    ir_d    = mem.imem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (iclass)
                    JUMP: begin
                        // pc_q already holds the incremented PC here
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    ILLEGAL: state_d = ST_HALT;
                    default: state_d = ST_EXECUTE;
                endcase
            end
            ST_EXECUTE: begin
                case (iclass)
                    BRANCH: begin
                        if (alu_zero) pc_d = pc_q + br_off;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    LOAD, STORE: state_d = ST_MEMORY;
                    default:     state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                if (mem.dmem_ack) begin
                    if (iclass == STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end
            end
            ST_WRITEBACK: begin
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        cyc_d = (state_q != ST_IDLE) ? cyc_q + 32'd1 : cyc_q;
        ret_d = retire ? ret_q + 32'd1 : ret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            cyc_q   <= 32'd0;
            ret_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
        end
    end

    // Strobes come straight from the state flops, so an async reset drops
    // any pending request in the same instant.
    assign mem.imem_req  = (state_q == ST_FETCH);
    assign mem.imem_addr = pc_q;
    assign mem.dmem_req  = (state_q == ST_MEMORY);
    assign mem.dmem_we   = (state_q == ST_MEMORY) && (iclass == STORE);
    assign alu_src       = ((state_q == ST_EXECUTE) || (state_q == ST_MEMORY)) &&
                           ((iclass == ALU_I) || (iclass == LOAD) || (iclass == STORE));
    assign reg_write     = (state_q == ST_WRITEBACK);
    assign mem_to_reg    = (state_q == ST_WRITEBACK) && (iclass == LOAD);
    assign halted        = (state_q == ST_HALT);
    assign instr         = ir_q;
    assign pc            = pc_q;
    assign cycle_cnt     = cyc_q;
    assign instret_cnt   = ret_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed scoreboard bench for mc_sequencer.
// Each instruction pushes a model-predicted result record, the bench then
// plays memory for it cycle by cycle and pops/compares on completion.
// A second instance with a high RESET_PC exercises j's upper PC bits.
module tb_mc_sequencer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] npc;
        logic [31:0] cycles;
        logic [31:0] rw;
        logic [31:0] rw_at;
        logic [31:0] m2r;
        logic [31:0] dreq;
        logic [31:0] we;
        logic [31:0] asrc;
        logic [31:0] hlt;
        logic [31:0] ret;
        logic [31:0] cc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] instr, pc, cycle_cnt, instret_cnt;
    logic        alu_src, reg_write, mem_to_reg, halted;

    logic        rst2 = 1'b0;
    logic        en2 = 1'b0;
    logic [31:0] instr2, pc2, cycle_cnt2, instret_cnt2;
    logic        alu_src2, reg_write2, mem_to_reg2, halted2;

    mc_sequencer_if mif ();
    mc_sequencer_if mif2 ();

    mc_sequencer #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mem(mif), .instr(instr),
        .alu_zero(alu_zero), .alu_src(alu_src), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc(pc), .halted(halted),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    mc_sequencer #(.RESET_PC(32'h1000_0000)) u_dut_hi (
        .clk(clk), .rst(rst2), .en(en2), .mem(mif2), .instr(instr2),
        .alu_zero(alu_zero), .alu_src(alu_src2), .reg_write(reg_write2),
        .mem_to_reg(mem_to_reg2), .pc(pc2), .halted(halted2),
        .cycle_cnt(cycle_cnt2), .instret_cnt(instret_cnt2)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    res_t        sb[$];
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_ret = 32'd0;
    logic [31:0] m_cc = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: predicts the outcome of one instruction from the
    // architectural rules, then advances the model PC/counters.
    task automatic push_exp(input logic [31:0] w, input logic z, input logic [31:0] dw);
        res_t        r;
        logic [31:0] pc4;
        r     = '0;
        pc4   = m_pc + 32'd4;
        r.addr = m_pc;
        r.npc  = pc4;
        case (w[31:26])
            6'h00: begin r.cycles = 32'd4; r.rw = 32'd1; r.rw_at = 32'd4; end
            6'h08, 6'h0D, 6'h0F: begin
                r.cycles = 32'd4; r.rw = 32'd1; r.rw_at = 32'd4; r.asrc = 32'd1;
            end
            6'h23: begin
                r.cycles = 32'd5 + dw; r.rw = 32'd1; r.rw_at = 32'd5 + dw;
                r.m2r = 32'd1; r.dreq = dw + 32'd1; r.asrc = dw + 32'd2;
            end
            6'h2B: begin
                r.cycles = 32'd4 + dw; r.dreq = dw + 32'd1;
                r.we = dw + 32'd1; r.asrc = dw + 32'd2;
            end
            6'h04: begin
                r.cycles = 32'd3;
                if (z) r.npc = pc4 + {{14{w[15]}}, w[15:0], 2'b00};
            end
            6'h02: begin r.cycles = 32'd2; r.npc = {pc4[31:28], w[25:0], 2'b00}; end
            default: begin r.cycles = 32'd2; r.hlt = 32'd1; end
        endcase
        if (r.hlt == 32'd0) m_ret = m_ret + 32'd1;
        m_cc  = m_cc + r.cycles;
        m_pc  = r.npc;
        r.ret = m_ret;
        r.cc  = m_cc;
        sb.push_back(r);
    endtask

    // Called at a negedge with the DUT in FETCH. Plays memory until the DUT
    // is back in FETCH or halted. stray=1 also holds both acks high outside
    // their request states.
    task automatic exec(input string name, input logic [31:0] w, input logic z,
                        input logic [31:0] dw, input logic stray);
        res_t        o, e;
        int          n;
        logic [31:0] dcnt;
        push_exp(w, z, dw);
        o        = '0;
        n        = 0;
        dcnt     = 32'd0;
        alu_zero = z;
        o.addr   = mif.imem_addr;
        do begin
            if (reg_write) begin
                o.rw = o.rw + 32'd1;
                if (o.rw_at == 32'd0) o.rw_at = 32'(n + 1);
            end
            if (mem_to_reg) o.m2r  = o.m2r + 32'd1;
            if (alu_src)    o.asrc = o.asrc + 32'd1;
            if (mif.dmem_req) begin
                dcnt   = dcnt + 32'd1;
                o.dreq = o.dreq + 32'd1;
                if (mif.dmem_we) o.we = o.we + 32'd1;
            end
            mif.imem_ack   = mif.imem_req | stray;
            mif.imem_rdata = mif.imem_req ? w : 32'hDEAD_BEEF;
            mif.dmem_ack   = (mif.dmem_req && (dcnt > dw)) | stray;
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!mif.imem_req && !halted && n < 40);
        mif.imem_ack = 1'b0;
        mif.dmem_ack = 1'b0;
        o.cycles = 32'(n);
        o.npc    = pc;
        o.hlt    = {31'd0, halted};
        o.ret    = instret_cnt;
        o.cc     = cycle_cnt;
        e = sb.pop_front();
        check({name, ".addr"},   o.addr,   e.addr);
        check({name, ".pc"},     o.npc,    e.npc);
        check({name, ".cycles"}, o.cycles, e.cycles);
        check({name, ".rw"},     o.rw,     e.rw);
        check({name, ".rw_at"},  o.rw_at,  e.rw_at);
        check({name, ".m2r"},    o.m2r,    e.m2r);
        check({name, ".dreq"},   o.dreq,   e.dreq);
        check({name, ".we"},     o.we,     e.we);
        check({name, ".asrc"},   o.asrc,   e.asrc);
        check({name, ".halted"}, o.hlt,    e.hlt);
        check({name, ".instret"}, o.ret,   e.ret);
        check({name, ".cycle"},  o.cc,     e.cc);
    endtask

    initial begin
        mif.imem_ack = 1'b0; mif.imem_rdata = 32'd0; mif.dmem_ack = 1'b0;
        mif2.imem_ack = 1'b0; mif2.imem_rdata = 32'd0; mif2.dmem_ack = 1'b0;
        #1 rst = 1'b1; rst2 = 1'b1;
        #11;
        check("rst.pc", pc, 32'd0);
        check("rst.ir", instr, 32'd0);
        check("rst.halted", {31'd0, halted}, 32'd0);
        check("rst.cycle", cycle_cnt, 32'd0);
        check("rst.instret", instret_cnt, 32'd0);
        check("rst.strobes", {26'd0, mif.imem_req, mif.dmem_req, mif.dmem_we,
                               reg_write, alu_src, mem_to_reg}, 32'd0);

        // IDLE holds while en=0 and does not count cycles
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle.req", {31'd0, mif.imem_req}, 32'd0);
        check("idle.cycle", cycle_cnt, 32'd0);

        en = 1'b1;
        @(negedge clk);
        exec("addi", 32'h2008_0005, 1'b0, 32'd0, 1'b0);
        en = 1'b0;  // dropping en outside IDLE must not stop the machine
        exec("j40", 32'h0800_0010, 1'b0, 32'd0, 1'b0);
        exec("beq_t", 32'h1000_FFFF, 1'b1, 32'd0, 1'b0);
        exec("beq_n", 32'h1000_FFFF, 1'b0, 32'd0, 1'b0);
        exec("beq_0", 32'h1000_0000, 1'b1, 32'd0, 1'b0);
        exec("lw", 32'h8C09_0010, 1'b0, 32'd3, 1'b0);
        exec("sw", 32'hAC09_0010, 1'b0, 32'd0, 1'b0);
        exec("add_stray", 32'h012A_5820, 1'b0, 32'd0, 1'b1);
        exec("lui", 32'h3C01_1234, 1'b0, 32'd0, 1'b0);
        exec("beq_fwd", 32'h1000_0003, 1'b1, 32'd0, 1'b0);
        exec("ill", 32'hFC00_0000, 1'b0, 32'd0, 1'b0);

        // HALT is absorbing but keeps counting
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt.req", {31'd0, mif.imem_req}, 32'd0);
        end
        check("halt.cycle", cycle_cnt, m_cc + 32'd5);
        check("halt.flag", {31'd0, halted}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("hrst.pc", pc, 32'd0);
        check("hrst.halted", {31'd0, halted}, 32'd0);
        check("hrst.cycle", cycle_cnt, 32'd0);
        check("hrst.instret", instret_cnt, 32'd0);

        // Reset while an sw waits for its ack
        m_pc = 32'd0; m_ret = 32'd0; m_cc = 32'd0;
        @(negedge clk) rst = 1'b0; en = 1'b1;
        @(negedge clk);
        exec("addi2", 32'h2008_0001, 1'b0, 32'd0, 1'b0);
        mif.imem_ack = 1'b1; mif.imem_rdata = 32'hAC09_0010;
        @(posedge clk);
        @(negedge clk);
        mif.imem_ack = 1'b0;
        for (int k = 0; k < 10 && !mif.dmem_req; k++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("swr.dreq", {31'd0, mif.dmem_req}, 32'd1);
        check("swr.we", {31'd0, mif.dmem_we}, 32'd1);
        check("swr.instret_pre", instret_cnt, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("swr.dreq_drop", {31'd0, mif.dmem_req}, 32'd0);
        check("swr.instret", instret_cnt, 32'd0);
        check("swr.pc", pc, 32'd0);
        en = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("swr.idle_req", {31'd0, mif.imem_req}, 32'd0);
        check("swr.idle_cycle", cycle_cnt, 32'd0);

        // j keeps the upper PC nibble
        rst2 = 1'b0; en2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("jhi.addr", mif2.imem_addr, 32'h1000_0000);
        mif2.imem_ack = 1'b1; mif2.imem_rdata = 32'h0800_0100;
        @(posedge clk);
        @(negedge clk);
        mif2.imem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("jhi.pc", pc2, 32'h1000_0400);
        check("jhi.instret", instret_cnt2, 32'd1);
        check("jhi.refetch", {31'd0, mif2.imem_req}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
